// File: rtl/decode_ctrl.sv
// Registered RV32I(M) decode/issue stage: ID/EX register with load-use bubbles and M-op hold.
// Define DECODE_CTRL_RV32M_EN to decode M-ops and enable the MD_BUSY multi-cycle sequencing.
package decode_ctrl_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    // ALU encodings line up with funct3 for add/sll/xor/srl/or/and
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SLL = 3'd1;
    localparam logic [2:0] ALU_SRA = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SRL = 3'd5;
    localparam logic [2:0] ALU_OR  = 3'd6;
    localparam logic [2:0] ALU_AND = 3'd7;

    localparam logic [2:0] CMP_BLT  = 3'b100;
    localparam logic [2:0] CMP_BLTU = 3'b110;

    localparam logic       ALUMUX1_RS1 = 1'b0;
    localparam logic       ALUMUX1_PC  = 1'b1;
    localparam logic [2:0] ALUMUX2_I_IMM = 3'd0;
    localparam logic [2:0] ALUMUX2_U_IMM = 3'd1;
    localparam logic [2:0] ALUMUX2_B_IMM = 3'd2;
    localparam logic [2:0] ALUMUX2_S_IMM = 3'd3;
    localparam logic [2:0] ALUMUX2_J_IMM = 3'd4;
    localparam logic [2:0] ALUMUX2_RS2   = 3'd5;
    localparam logic       CMPMUX_RS2   = 1'b0;
    localparam logic       CMPMUX_I_IMM = 1'b1;

    localparam logic [3:0] RFMUX_ALU_OUT  = 4'd0;
    localparam logic [3:0] RFMUX_BR_EN    = 4'd1;
    localparam logic [3:0] RFMUX_U_IMM    = 4'd2;
    localparam logic [3:0] RFMUX_LW       = 4'd3;
    localparam logic [3:0] RFMUX_PC_PLUS4 = 4'd4;
    localparam logic [3:0] RFMUX_LB       = 4'd5;
    localparam logic [3:0] RFMUX_LBU      = 4'd6;
    localparam logic [3:0] RFMUX_LH       = 4'd7;
    localparam logic [3:0] RFMUX_LHU      = 4'd8;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [2:0] aluop;
        logic [2:0] cmpop;
        logic       load_regfile;
        logic       alumux1_sel;
        logic [2:0] alumux2_sel;
        logic       cmpmux_sel;
        logic [3:0] regfilemux_sel;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] mem_byte_enable;
        logic       branch;
        logic       jump;
        logic       muldiv;
    } rv32i_control_word;

endpackage

module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 33
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [31:0]       if_pc,
    output logic              id_ready,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output rv32i_control_word ex_ctrl,
    output logic [31:0]       ex_pc,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic              ex_illegal,
    output logic              muldiv_start,
    output logic [2:0]        muldiv_op,
    output logic              muldiv_busy,
    output logic              muldiv_done
);

    if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_lat_check
        $error("decode_ctrl: MUL_LAT and DIV_LAT must be at least 1");
    end

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign funct7 = if_instr[31:25];

    rv32i_control_word ctrl;
    logic              illegal;

    always_comb begin : decode
        ctrl        = '0;
        ctrl.opcode = opcode;
        ctrl.funct3 = funct3;
        illegal     = 1'b0;
        case (opcode)
            OP_LUI: begin
                ctrl.load_regfile   = 1'b1;
                ctrl.regfilemux_sel = RFMUX_U_IMM;
            end
            OP_AUIPC: begin
                ctrl.load_regfile = 1'b1;
                ctrl.alumux1_sel  = ALUMUX1_PC;
                ctrl.alumux2_sel  = ALUMUX2_U_IMM;
            end
            OP_JAL: begin
                ctrl.load_regfile   = 1'b1;
                ctrl.jump           = 1'b1;
                ctrl.alumux1_sel    = ALUMUX1_PC;
                ctrl.alumux2_sel    = ALUMUX2_J_IMM;
                ctrl.regfilemux_sel = RFMUX_PC_PLUS4;
            end
            OP_JALR: begin
                ctrl.load_regfile   = 1'b1;
                ctrl.jump           = 1'b1;
                ctrl.alumux2_sel    = ALUMUX2_I_IMM;
                ctrl.regfilemux_sel = RFMUX_PC_PLUS4;
            end
            OP_BR: begin
                ctrl.branch      = 1'b1;
                ctrl.cmpop       = funct3;
                ctrl.cmpmux_sel  = CMPMUX_RS2;
                ctrl.alumux1_sel = ALUMUX1_PC;
                ctrl.alumux2_sel = ALUMUX2_B_IMM;
            end
            OP_LOAD: begin
                ctrl.load_regfile = 1'b1;
                ctrl.mem_read     = 1'b1;
                ctrl.alumux2_sel  = ALUMUX2_I_IMM;
                case (funct3)
                    3'b000:  ctrl.regfilemux_sel = RFMUX_LB;
                    3'b001:  ctrl.regfilemux_sel = RFMUX_LH;
                    3'b100:  ctrl.regfilemux_sel = RFMUX_LBU;
                    3'b101:  ctrl.regfilemux_sel = RFMUX_LHU;
                    default: ctrl.regfilemux_sel = RFMUX_LW;
                endcase
            end
            OP_STORE: begin
                ctrl.mem_write   = 1'b1;
                ctrl.alumux2_sel = ALUMUX2_S_IMM;
                case (funct3)
                    3'b000:  ctrl.mem_byte_enable = 4'b0001;
                    3'b001:  ctrl.mem_byte_enable = 4'b0011;
                    default: ctrl.mem_byte_enable = 4'b1111;
                endcase
            end
            OP_IMM: begin
                ctrl.load_regfile = 1'b1;
                ctrl.alumux2_sel  = ALUMUX2_I_IMM;
                ctrl.aluop        = funct3;
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    ctrl.cmpop          = (funct3 == 3'b010) ? CMP_BLT : CMP_BLTU;
                    ctrl.cmpmux_sel     = CMPMUX_I_IMM;
                    ctrl.regfilemux_sel = RFMUX_BR_EN;
                end else if (funct3 == 3'b101) begin
                    ctrl.aluop = funct7[5] ? ALU_SRA : ALU_SRL;
                end
            end
            OP_REG: begin
                if (funct7 == 7'b0000001) begin
`ifdef DECODE_CTRL_RV32M_EN
                    ctrl.load_regfile = 1'b1;
                    ctrl.muldiv       = 1'b1;
                    ctrl.alumux2_sel  = ALUMUX2_RS2;
`else
                    illegal = 1'b1;
`endif
                end else begin
                    ctrl.load_regfile = 1'b1;
                    ctrl.alumux2_sel  = ALUMUX2_RS2;
                    ctrl.aluop        = funct3;
                    if (funct3 == 3'b010 || funct3 == 3'b011) begin
                        ctrl.cmpop          = (funct3 == 3'b010) ? CMP_BLT : CMP_BLTU;
                        ctrl.cmpmux_sel     = CMPMUX_RS2;
                        ctrl.regfilemux_sel = RFMUX_BR_EN;
                    end else if (funct3 == 3'b000) begin
                        ctrl.aluop = funct7[5] ? ALU_SUB : ALU_ADD;
                    end else if (funct3 == 3'b101) begin
                        ctrl.aluop = funct7[5] ? ALU_SRA : ALU_SRL;
                    end
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    rv32i_control_word ex_ctrl_q;
    logic              ex_valid_q, ex_valid_d, ex_illegal_q;
    logic [31:0]       ex_pc_q;
    logic [4:0]        ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic              uses_rs1, uses_rs2, hazard, load;
    logic              run, md_issue, md_last;

    assign uses_rs1 = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign uses_rs2 = opcode inside {OP_BR, OP_STORE, OP_REG};

    // x0 as a load destination never creates a dependency
    assign hazard = ex_valid_q && (ex_ctrl_q.opcode == OP_LOAD) && (ex_rd_q != 5'd0) &&
                    ((uses_rs1 && rs1 == ex_rd_q) || (uses_rs2 && rs2 == ex_rd_q));

    assign id_ready = rst && run && !flush && !hazard && (!ex_valid_q || ex_ready);
    assign load     = id_ready && if_valid;

`ifdef DECODE_CTRL_RV32M_EN
    localparam logic [0:0] StRun    = 1'b0;
    localparam logic [0:0] StMdBusy = 1'b1;
    localparam int unsigned MaxLat = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    logic [0:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      md_op_q;
    logic            is_mop;

    assign is_mop   = (opcode == OP_REG) && (funct7 == 7'b0000001);
    assign run      = (state_q == StRun);
    assign md_issue = load && is_mop;
    assign md_last  = (cnt_q == '0);

    always_comb begin : md_next
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = StRun;
            cnt_d   = '0;
        end else if (state_q == StMdBusy) begin
            if (md_last) state_d = StRun;
            else         cnt_d   = cnt_q - CntW'(1);
        end else if (md_issue) begin
            state_d = StMdBusy;
            cnt_d   = funct3[2] ? CntW'(DIV_LAT - 1) : CntW'(MUL_LAT - 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
            md_op_q <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (md_issue) md_op_q <= funct3;
        end
    end

    assign muldiv_start = md_issue;
    assign muldiv_op    = md_op_q;
    assign muldiv_busy  = (state_q == StMdBusy);
    assign muldiv_done  = muldiv_busy && md_last && !flush;
`else
    assign run          = 1'b1;
    assign md_issue     = 1'b0;
    assign md_last      = 1'b0;
    assign muldiv_start = 1'b0;
    assign muldiv_op    = 3'b000;
    assign muldiv_busy  = 1'b0;
    assign muldiv_done  = 1'b0;
`endif

    // An issuing M-op stays invisible to EX until its last busy cycle has elapsed
    always_comb begin : valid_next
        ex_valid_d = ex_valid_q;
        if (flush)                      ex_valid_d = 1'b0;
        else if (!run)                  ex_valid_d = md_last;
        else if (load)                  ex_valid_d = !md_issue;
        else if (ex_valid_q && ex_ready) ex_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_pc_q      <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_rd_q      <= '0;
            ex_illegal_q <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            if (load) begin
                ex_ctrl_q    <= ctrl;
                ex_pc_q      <= if_pc;
                ex_rs1_q     <= rs1;
                ex_rs2_q     <= rs2;
                ex_rd_q      <= rd;
                ex_illegal_q <= illegal;
            end
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign ex_pc      = ex_pc_q;
    assign ex_rs1     = ex_rs1_q;
    assign ex_rs2     = ex_rs2_q;
    assign ex_rd      = ex_rd_q;
    assign ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed self-checking bench for decode_ctrl; M-op sequences run when DECODE_CTRL_RV32M_EN is set.
module tb_decode_ctrl;
    import decode_ctrl_pkg::*;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] I_LW    = 32'h0001_2283;  // lw   x5,0(x2)
    localparam logic [31:0] I_ADD   = 32'h0072_8333;  // add  x6,x5,x7
    localparam logic [31:0] I_LW0   = 32'h0001_2003;  // lw   x0,0(x2)
    localparam logic [31:0] I_ADD0  = 32'h0070_0333;  // add  x6,x0,x7
    localparam logic [31:0] I_SUB   = 32'h4041_8133;  // sub  x2,x3,x4
    localparam logic [31:0] I_SW    = 32'h0051_2223;  // sw   x5,4(x2)
    localparam logic [31:0] I_ILL   = 32'h0000_007F;
    localparam logic [31:0] I_SRAI  = 32'h4031_5093;  // srai x1,x2,3
    localparam logic [31:0] I_JAL   = 32'h0000_00EF;  // jal  x1,0
    localparam logic [31:0] I_DIV   = 32'h0252_41B3;  // div  x3,x4,x5
    localparam logic [31:0] I_MUL   = 32'h0231_00B3;  // mul  x1,x2,x3

    logic              clk = 1'b0;
    logic              rst;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc;
    logic              id_ready;
    logic              flush;
    logic              ex_ready;
    logic              ex_valid;
    rv32i_control_word ex_ctrl;
    logic [31:0]       ex_pc;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic              ex_illegal;
    logic              muldiv_start;
    logic [2:0]        muldiv_op;
    logic              muldiv_busy;
    logic              muldiv_done;

    int checks = 0;
    int errors = 0;

    decode_ctrl #(.MUL_LAT(3), .DIV_LAT(33)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .id_ready     (id_ready),
        .flush        (flush),
        .ex_ready     (ex_ready),
        .ex_valid     (ex_valid),
        .ex_ctrl      (ex_ctrl),
        .ex_pc        (ex_pc),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_illegal   (ex_illegal),
        .muldiv_start (muldiv_start),
        .muldiv_op    (muldiv_op),
        .muldiv_busy  (muldiv_busy),
        .muldiv_done  (muldiv_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
    endtask

`ifdef DECODE_CTRL_RV32M_EN
    task automatic run_md(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                          input int lat, input logic [2:0] op, input logic [4:0] rd);
        int n;
        int done_at;
        int done_cnt;
        drive(1'b1, ins, pc);
        #1 check({tag, "_start"}, 64'(muldiv_start), 64'd1);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        check({tag, "_op"}, 64'(muldiv_op), 64'(op));
        check({tag, "_hidden"}, 64'(ex_valid), 64'd0);
        n = 0;
        done_at = 0;
        done_cnt = 0;
        while (muldiv_busy && n < 100) begin
            if (muldiv_done) begin
                done_at = n + 1;
                done_cnt++;
            end
            if (ex_valid) check({tag, "_valid_in_busy"}, 64'(ex_valid), 64'd0);
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(lat));
        check({tag, "_done_last"}, 64'(done_at), 64'(lat));
        check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check({tag, "_present"}, 64'(ex_valid), 64'd1);
        check({tag, "_rd"}, 64'(ex_rd), 64'(rd));
        check({tag, "_muldiv"}, 64'(ex_ctrl.muldiv), 64'd1);
        @(negedge clk);
    endtask
`endif

    initial begin
        rst      = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        drive(1'b1, I_ADDI, 32'h100);
        repeat (2) @(negedge clk);
        check("rst_id_ready", 64'(id_ready), 64'd0);
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_ex_ctrl", 64'(ex_ctrl), 64'd0);
        check("rst_ex_pc", 64'(ex_pc), 64'd0);
        check("rst_md_busy", 64'(muldiv_busy), 64'd0);
        check("rst_md_start", 64'(muldiv_start), 64'd0);

        // addi issues on the first edge after reset release
        rst = 1'b1;
        #1 check("addi_id_ready", 64'(id_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        check("addi_valid", 64'(ex_valid), 64'd1);
        check("addi_aluop", 64'(ex_ctrl.aluop), 64'd0);
        check("addi_ld_rf", 64'(ex_ctrl.load_regfile), 64'd1);
        check("addi_rd", 64'(ex_rd), 64'd1);
        check("addi_illegal", 64'(ex_illegal), 64'd0);
        check("addi_pc", 64'(ex_pc), 64'h100);
        @(negedge clk);
        check("drain_valid", 64'(ex_valid), 64'd0);

        // Load-use: one bubble
        drive(1'b1, I_LW, 32'h200);
        @(negedge clk);
        check("lw_valid", 64'(ex_valid), 64'd1);
        check("lw_mem_read", 64'(ex_ctrl.mem_read), 64'd1);
        check("lw_rfmux", 64'(ex_ctrl.regfilemux_sel), 64'd3);
        drive(1'b1, I_ADD, 32'h204);
        #1 check("lu_id_ready_stall", 64'(id_ready), 64'd0);
        @(negedge clk);
        check("lu_bubble", 64'(ex_valid), 64'd0);
        #1 check("lu_id_ready_after", 64'(id_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        check("lu_add_valid", 64'(ex_valid), 64'd1);
        check("lu_add_pc", 64'(ex_pc), 64'h204);
        check("lu_add_rs1", 64'(ex_rs1), 64'd5);
        check("lu_add_rs2", 64'(ex_rs2), 64'd7);
        check("lu_add_rd", 64'(ex_rd), 64'd6);
        @(negedge clk);

        // Load to x0: no bubble
        drive(1'b1, I_LW0, 32'h300);
        @(negedge clk);
        drive(1'b1, I_ADD0, 32'h304);
        #1 check("x0_id_ready", 64'(id_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        check("x0_add_valid", 64'(ex_valid), 64'd1);
        check("x0_add_pc", 64'(ex_pc), 64'h304);
        @(negedge clk);

        // EX back-pressure holds the entry
        drive(1'b1, I_SUB, 32'h400);
        @(negedge clk);
        check("sub_aluop", 64'(ex_ctrl.aluop), 64'd3);
        ex_ready = 1'b0;
        drive(1'b1, I_SW, 32'h404);
        for (int i = 0; i < 4; i++) begin
            #1 check("stall_id_ready", 64'(id_ready), 64'd0);
            @(negedge clk);
            check("stall_valid", 64'(ex_valid), 64'd1);
            check("stall_pc", 64'(ex_pc), 64'h400);
            check("stall_rd", 64'(ex_rd), 64'd2);
        end
        ex_ready = 1'b1;
        #1 check("unstall_id_ready", 64'(id_ready), 64'd1);
        @(negedge clk);
        check("sw_pc", 64'(ex_pc), 64'h404);
        check("sw_mem_write", 64'(ex_ctrl.mem_write), 64'd1);
        check("sw_mbe", 64'(ex_ctrl.mem_byte_enable), 64'hF);
        check("sw_ld_rf", 64'(ex_ctrl.load_regfile), 64'd0);

        // Back-to-back issue
        drive(1'b1, I_ILL, 32'h408);
        #1 check("b2b_id_ready", 64'(id_ready), 64'd1);
        @(negedge clk);
        check("ill_illegal", 64'(ex_illegal), 64'd1);
        check("ill_ld_rf", 64'(ex_ctrl.load_regfile), 64'd0);
        drive(1'b1, I_SRAI, 32'h40C);
        @(negedge clk);
        check("srai_pc", 64'(ex_pc), 64'h40C);
        check("srai_aluop", 64'(ex_ctrl.aluop), 64'd2);
        check("srai_illegal", 64'(ex_illegal), 64'd0);
        drive(1'b1, I_JAL, 32'h410);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        check("jal_valid", 64'(ex_valid), 64'd1);
        check("jal_jump", 64'(ex_ctrl.jump), 64'd1);
        check("jal_rfmux", 64'(ex_ctrl.regfilemux_sel), 64'd4);
        check("jal_alumux1", 64'(ex_ctrl.alumux1_sel), 64'd1);
        @(negedge clk);

        // Flush kills the entry and blocks issue for that cycle
        drive(1'b1, I_ADDI, 32'h500);
        @(negedge clk);
        check("fl_pre_valid", 64'(ex_valid), 64'd1);
        drive(1'b1, I_SUB, 32'h504);
        flush    = 1'b1;
        ex_ready = 1'b0;
        #1 check("fl_id_ready", 64'(id_ready), 64'd0);
        @(negedge clk);
        flush    = 1'b0;
        ex_ready = 1'b1;
        check("fl_valid", 64'(ex_valid), 64'd0);
        #1 check("fl_id_ready_after", 64'(id_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        check("fl_next_pc", 64'(ex_pc), 64'h504);
        check("fl_next_valid", 64'(ex_valid), 64'd1);
        @(negedge clk);

`ifdef DECODE_CTRL_RV32M_EN
        run_md("div", I_DIV, 32'h600, 33, 3'b100, 5'd3);
        run_md("mul", I_MUL, 32'h620, 3, 3'b000, 5'd1);

        // Flush on the 10th busy cycle of a div
        drive(1'b1, I_DIV, 32'h700);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        repeat (9) @(negedge clk);
        check("mdfl_busy", 64'(muldiv_busy), 64'd1);
        drive(1'b1, I_ADDI, 32'h704);
        flush = 1'b1;
        #1 check("mdfl_done", 64'(muldiv_done), 64'd0);
        check("mdfl_id_ready", 64'(id_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        check("mdfl_valid", 64'(ex_valid), 64'd0);
        check("mdfl_busy_after", 64'(muldiv_busy), 64'd0);
        #1 check("mdfl_id_ready_after", 64'(id_ready), 64'd1);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        check("mdfl_next_pc", 64'(ex_pc), 64'h704);
        check("mdfl_next_valid", 64'(ex_valid), 64'd1);
        check("mdfl_no_done", 64'(muldiv_done), 64'd0);
        @(negedge clk);
`else
        // Without M support mul is an illegal 1-cycle issue
        drive(1'b1, I_MUL, 32'h800);
        #1 check("mul_id_ready", 64'(id_ready), 64'd1);
        check("mul_start", 64'(muldiv_start), 64'd0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        check("mul_valid", 64'(ex_valid), 64'd1);
        check("mul_illegal", 64'(ex_illegal), 64'd1);
        check("mul_ld_rf", 64'(ex_ctrl.load_regfile), 64'd0);
        check("mul_busy", 64'(muldiv_busy), 64'd0);
        check("mul_done", 64'(muldiv_done), 64'd0);
        check("mul_op", 64'(muldiv_op), 64'd0);
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_ctrl.md
# decode_ctrl

Registered decode/issue stage for the RV32I(M) pipeline. It decodes the IF/ID instruction into an `rv32i_control_word` and holds it in the ID/EX register under a valid/ready handshake. It detects load-use hazards and inserts bubbles. It sequences multi-cycle multiply/divide operations by holding the M-op in ID/EX until its fixed latency has elapsed. It sits between the IF/ID register and the EX stage, and supersedes the purely combinational control lookup.

## Interface
Parameters:
- `MUL_LAT`, default 3: cycles an M-op with funct3 < 4 (mul/mulh/mulhsu/mulhu) occupies the iterative unit; must be ≥ 1.
- `DIV_LAT`, default 33: cycles an M-op with funct3 ≥ 4 (div/divu/rem/remu) occupies the unit; must be ≥ 1.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `if_valid`, in, 1: IF/ID holds a valid instruction.
- `if_instr`, in, 32: instruction word.
- `if_pc`, in, 32: PC of `if_instr`.
- `id_ready`, out, 1: decode accepts the IF/ID instruction this cycle.
- `flush`, in, 1: EX redirect; kills the ID/EX entry and aborts any M-op.
- `ex_ready`, in, 1: EX accepts the ID/EX entry.
- `ex_valid`, out, 1: ID/EX entry valid.
- `ex_ctrl`, out, `rv32i_control_word`: registered control word.
- `ex_pc`, out, 32: registered PC.
- `ex_rs1`, `ex_rs2`, `ex_rd`, out, 5 each: registered register indices.
- `ex_illegal`, out, 1: registered entry is an unrecognised opcode.
- `muldiv_start`, out, 1: one-cycle pulse when an M-op enters ID/EX.
- `muldiv_op`, out, 3: funct3 of the current M-op.
- `muldiv_busy`, out, 1: high in MD_BUSY.
- `muldiv_done`, out, 1: one-cycle pulse on the last busy cycle.

## Operation
- Decoding follows the team's RV32I control table: lui, auipc, jal, jalr, br, load, store, imm and reg, with the slt/sltu paths routed through the comparator, sra/srl selected by funct7[5], and sub selected by funct7[5]. An unknown opcode yields the default control word (no regfile load, no memory access) with `ex_illegal` = 1.
- Register usage:
  - rs1 is used by every opcode except lui, auipc and jal.
  - rs2 is used by br, store and reg.
- Load-use hazard: the ID/EX entry is valid and a load, its `ex_rd` ≠ 0, and the decoded instruction uses a register equal to `ex_rd`.
  - `id_ready` = 0.
  - When EX accepts the load, the next ID/EX value is a bubble (`ex_valid` = 0).
  - The instruction stays in IF/ID and issues the cycle after the bubble.
- ID/EX load condition: state RUN, no flush, no hazard, `if_valid`, and (`!ex_valid` || `ex_ready`). `id_ready` equals this condition without the `if_valid` term.
- If `ex_valid` && `ex_ready` and nothing new loads, `ex_valid` clears.
- FSM states:
  - RUN: normal issue. When an M-op (op_reg, funct7 = 7'b0000001) loads, assert `muldiv_start`, latch funct3 into `muldiv_op`, load the counter with `MUL_LAT`-1 or `DIV_LAT`-1, and go to MD_BUSY.
  - MD_BUSY: `ex_valid` = 0 and `id_ready` = 0; the counter decrements each cycle. At count 0, pulse `muldiv_done`, set `ex_valid` = 1 the next cycle, and return to RUN. The M-op then completes through the normal handshake.
- `flush` has priority over all other events in the same cycle:
  - next `ex_valid` = 0, next state RUN, counter cleared;
  - no `muldiv_done` pulse is issued;
  - `id_ready` = 0 that cycle.
- `rd` = x0 is never a hazard source.

## Timing
- Decode-to-EX latency: 1 cycle.
- An M-op is presented to EX exactly LAT+1 cycles after its `muldiv_start` cycle (LAT = `MUL_LAT` or `DIV_LAT`).
- Reset (`rst` low), asynchronously:
  - `ex_valid`, `ex_illegal`, `muldiv_start`, `muldiv_busy`, `muldiv_done`, `muldiv_op` = 0;
  - `ex_ctrl` = all-zero, `ex_pc` and the rs/rd indices = 0;
  - state RUN, counter 0.
- `id_ready` = 0 while `rst` is low.
- Reset mid-MD_BUSY abandons the op with no `done` pulse.
- While `ex_valid` && !`ex_ready`, all `ex_*` outputs stay stable.
- Back-to-back issue is sustained at 1 instruction/cycle when there is no hazard and `ex_ready` is held high.

## Configuration
- `DECODE_CTRL_RV32M_EN` defined: M-ops are decoded and the MD_BUSY sequencing described above applies.
- `DECODE_CTRL_RV32M_EN` undefined:
  - op_reg with funct7 = 7'b0000001 decodes as illegal (`ex_illegal` = 1, `load_regfile` = 0) and issues in 1 cycle;
  - `muldiv_*` outputs are tied to 0;
  - the MD_BUSY state and counter are absent.

## Test plan
- Reset, then issue `addi x1,x0,5` with `ex_ready` = 1 → next cycle `ex_valid` = 1, aluop = alu_add, `load_regfile` = 1, `ex_rd` = 1, `ex_illegal` = 0.
- `lw x5,0(x2)` followed by `add x6,x5,x7`, `ex_ready` = 1 → `id_ready` = 0 for 1 cycle, one bubble (`ex_valid` = 0), and the add reaches EX 2 cycles after the lw. The same sequence with `rd` = x0 produces no bubble.
- `div x3,x4,x5` with `DIV_LAT` = 33 → `muldiv_start` pulse, `muldiv_op` = 3'b100, `muldiv_busy` high for 33 cycles, `muldiv_done` on the last busy cycle, `ex_valid` = 1 on the following cycle; `mul` with `MUL_LAT` = 3 gives 3 busy cycles.
- Assert `flush` on the 10th busy cycle of a div → next cycle `ex_valid` = 0, `muldiv_busy` = 0, no `muldiv_done`, and `id_ready` = 1 for a pending instruction.
- Hold `ex_ready` = 0 for 4 cycles with `ex_valid` = 1 → `ex_*` outputs unchanged, `id_ready` = 0. Opcode 7'b1111111 yields `ex_illegal` = 1 and `load_regfile` = 0.
- Build without `DECODE_CTRL_RV32M_EN`, issue `mul x1,x2,x3` → 1-cycle issue with `ex_illegal` = 1, and `muldiv_*` stay 0.
